// File: rtl/lift_input_conditioner.sv
// lift_input_conditioner: sync, debounce and request-latch raw lift inputs into controller conditions x1..x14
module lift_input_conditioner #(
  parameter int N_IN = 14,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W = 3,
  parameter logic [N_IN-1:0] LATCH_MASK = 14'h0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] raw_in,
  input  logic [N_IN-1:0] clr,
  output logic [N_IN-1:0] x_out,
  output logic [N_IN-1:0] chg_pulse,
  output logic [7:0]      glitch_cnt
);
  logic [N_IN-1:0] s1_q, s2_q, db_q, db_d, chg_q, chg_d, lat_q, lat_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];
  logic [7:0] glitch_q, glitch_d;
  logic [8:0] sum;
  // stable-count filter per channel; a return to the old level with a nonzero count is a glitch
  always_comb begin
    db_d = db_q;
    cnt_d = cnt_q;
    chg_d = '0;
    lat_d = lat_q & ~clr & LATCH_MASK;
    sum = {1'b0, glitch_q};
    for (int i = 0; i < N_IN; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
        sum = sum + 9'(cnt_q[i] != '0);
      end else if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
        db_d[i] = s2_q[i];
        cnt_d[i] = '0;
        chg_d[i] = 1'b1;
        lat_d[i] = lat_d[i] | (s2_q[i] & LATCH_MASK[i]);
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    glitch_d = sum[8] ? 8'hff : sum[7:0];
  end
  // two-flop synchroniser plus all filter, latch and glitch-counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      cnt_q <= '{default: '0};
      chg_q <= '0;
      lat_q <= '0;
      glitch_q <= '0;
    end else begin
      s1_q <= raw_in;
      s2_q <= s1_q;
      db_q <= db_d;
      cnt_q <= cnt_d;
      chg_q <= chg_d;
      lat_q <= lat_d;
      glitch_q <= glitch_d;
    end
  end
  assign x_out = (LATCH_MASK & lat_q) | (~LATCH_MASK & db_q);
  assign chg_pulse = chg_q;
  assign glitch_cnt = glitch_q;
endmodule

// File: tb/tb_lift_input_conditioner.sv
// tb_lift_input_conditioner: directed and random scoreboard checks against a behavioural filter model
module tb_lift_input_conditioner;
  localparam int N = 14;
  localparam int DB = 4;
  localparam logic [N-1:0] MASK = 14'h0001;
  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] chg;
    logic [7:0]   g;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] raw_in = '0, clr = '0;
  logic [N-1:0] x_out, chg_pulse;
  logic [7:0] glitch_cnt;
  exp_t q[$];
  int n_checks = 0, n_pass = 0, cyc = 0;
  logic [N-1:0] m_r1, m_r2, m_db, m_lat, m_chg;
  int m_run [N];
  int m_gc;
  lift_input_conditioner dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .clr(clr),
    .x_out(x_out), .chg_pulse(chg_pulse), .glitch_cnt(glitch_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask
  // The synchronised level seen by the filter is the raw level from two edges earlier;
  // a level different from the accepted one must persist DB consecutive edges to be adopted.
  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] c, input bit rs);
    logic [N-1:0] sv, set;
    exp_t e;
    if (rs) begin
      m_r1 = '0; m_r2 = '0; m_db = '0; m_lat = '0; m_chg = '0; m_gc = 0;
      foreach (m_run[i]) m_run[i] = 0;
    end else begin
      sv = m_r2;
      m_r2 = m_r1;
      m_r1 = r;
      set = '0;
      m_chg = '0;
      for (int i = 0; i < N; i++) begin
        if (sv[i] == m_db[i]) begin
          if (m_run[i] > 0) m_gc = (m_gc >= 255) ? 255 : m_gc + 1;
          m_run[i] = 0;
        end else if (m_run[i] + 1 >= DB) begin
          m_db[i] = sv[i];
          m_run[i] = 0;
          m_chg[i] = 1'b1;
          set[i] = sv[i];
        end else m_run[i]++;
      end
      m_lat = ((m_lat & ~c) | set) & MASK;
    end
    e.x = (MASK & m_lat) | (~MASK & m_db);
    e.chg = m_chg;
    e.g = 8'(m_gc);
    q.push_back(e);
  endtask
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] c, input bit rs);
    raw_in = r;
    clr = c;
    rst = rs;
    @(posedge clk);
    model_edge(r, c, rs);
    cyc++;
    #1;
  endtask
  // monitor: every cycle the DUT presents a settled result that is checked against the queue head
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("x_out", int'(x_out), int'(e.x));
      chk("chg_pulse", int'(chg_pulse), int'(e.chg));
      chk("glitch_cnt", int'(glitch_cnt), int'(e.g));
    end
  end
  initial begin
    logic [N-1:0] v;
    int p;
    repeat (2) step('0, '0, 1);
    // single channel rise: x5 appears after the sixth edge with a one-cycle pulse
    v = '0; v[5] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(v, '0, 0);
      if (k == 5) chk("t1_x5_early", int'(x_out[5]), 0);
      if (k == 6) begin
        chk("t1_x5_rise", int'(x_out[5]), 1);
        chk("t1_pulse", int'(chg_pulse[5]), 1);
      end
      if (k == 7) chk("t1_pulse_end", int'(chg_pulse[5]), 0);
    end
    chk("t1_glitch", int'(glitch_cnt), 0);
    // three simultaneous short glitches
    v[1] = 1; v[2] = 1; v[4] = 1;
    repeat (2) step(v, '0, 0);
    v[1] = 0; v[2] = 0; v[4] = 0;
    for (int k = 1; k <= 4; k++) begin
      step(v, '0, 0);
      if (k == 2) chk("t4_before", int'(glitch_cnt), 0);
      if (k == 3) chk("t4_plus3", int'(glitch_cnt), 3);
    end
    // latched request channel 0
    v[0] = 1;
    repeat (8) step(v, '0, 0);
    v[0] = 0;
    repeat (8) step(v, '0, 0);
    chk("t3_held", int'(x_out[0]), 1);
    step(v, 14'h0001, 0);
    chk("t3_cleared", int'(x_out[0]), 0);
    v[0] = 1;
    for (int k = 1; k <= 6; k++) step(v, (k == 6) ? 14'h0001 : 14'h0000, 0);
    chk("t3_set_wins", int'(x_out[0]), 1);
    // short pulses on ch3 until the glitch counter saturates
    for (int k = 0; k < 300; k++) begin
      v[3] = 1;
      repeat (3) step(v, '0, 0);
      v[3] = 0;
      repeat (2) step(v, '0, 0);
    end
    repeat (3) step(v, '0, 0);
    chk("t2_x3_low", int'(x_out[3]), 0);
    chk("t2_saturate", int'(glitch_cnt), 255);
    // reset in the middle of a debounce on ch7
    v = '0;
    repeat (8) step(v, '0, 0);
    v[7] = 1;
    repeat (4) step(v, '0, 0);
    step(v, '0, 1);
    chk("t5_x", int'(x_out), 0);
    chk("t5_chg", int'(chg_pulse), 0);
    chk("t5_glitch", int'(glitch_cnt), 0);
    for (int k = 1; k <= 6; k++) begin
      step(v, '0, 0);
      if (k == 5) chk("t5_x7_wait", int'(x_out[7]), 0);
      if (k == 6) chk("t5_x7_rise", int'(x_out[7]), 1);
    end
    // random bouncing inputs, occasional clears and resets
    for (int b = 0; b < 30; b++) begin
      p = (b % 3 == 0) ? 2 : (b % 3 == 1) ? 6 : 20;
      for (int k = 0; k < 100; k++) begin
        for (int i = 0; i < N; i++) if ($urandom_range(0, p - 1) == 0) v[i] = ~v[i];
        step(v, ($urandom_range(0, 7) == 0) ? N'($urandom) : '0, $urandom_range(0, 399) == 0);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
